// File: rtl/victim_swap_ctrl_pkg.sv
// Shared types and constants for the L1 / victim-cache miss sequencer.
package victim_swap_ctrl_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BLK_W  = ADDR_W - 3;
  localparam int unsigned WORDS  = 8;
  localparam int unsigned WORD_W = LINE_W / WORDS;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StProbe,
    StSwap,
    StWb,
    StFill,
    StRefill,
    StDone
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [SEL_W-1:0]  sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/line_word_mux.sv
// Selects one 32-bit word out of a cache line.
module line_word_mux
  import victim_swap_ctrl_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [WORD_W-1:0] word_o
);

  assign word_o = line_word(line_i, sel_i);

endmodule

// File: rtl/victim_swap_ctrl.sv
// Miss sequencer: probes the victim cache on an L1 miss, then either swaps lines or
// writes back / fills from memory, pushing the clean L1 victim into the victim cache.
module victim_swap_ctrl #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              l1_hit,
  input  logic              l1_victim_valid,
  input  logic              l1_victim_dirty,
  input  logic [ADDR_W-4:0] l1_victim_addr,
  input  logic [LINE_W-1:0] l1_victim_line,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_line,
  output logic [ADDR_W-4:0] vc_addr,
  output logic              vc_evict,
  output logic [LINE_W-1:0] vc_in_line,
  output logic              l1_fill_we,
  output logic [LINE_W-1:0] l1_fill_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       dout
);
  import victim_swap_ctrl_pkg::*;

  localparam int unsigned BlkW = ADDR_W - 3;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                vic_valid_q, vic_valid_d;
  logic                vic_dirty_q, vic_dirty_d;
  logic [BlkW-1:0]     vic_addr_q, vic_addr_d;
  logic [LINE_W-1:0]   vic_line_q, vic_line_d;
  logic [LINE_W-1:0]   result_q, result_d;
  logic [31:0]         result_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
      vic_addr_q  <= '0;
      vic_line_q  <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vic_valid_q <= vic_valid_d;
      vic_dirty_q <= vic_dirty_d;
      vic_addr_q  <= vic_addr_d;
      vic_line_q  <= vic_line_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    vic_valid_d = vic_valid_q;
    vic_dirty_d = vic_dirty_q;
    vic_addr_d  = vic_addr_q;
    vic_line_d  = vic_line_q;
    result_d    = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !l1_hit) begin
          addr_d      = req_addr;
          vic_valid_d = l1_victim_valid;
          vic_dirty_d = l1_victim_dirty;
          vic_addr_d  = l1_victim_addr;
          vic_line_d  = l1_victim_line;
          state_d     = StProbe;
        end
      end
      StProbe: begin
        if (vc_hit) begin
          state_d = StSwap;
        end else if (vic_valid_q && vic_dirty_q) begin
          state_d = StWb;
        end else begin
          state_d = StFill;
        end
      end
      StSwap: begin
        result_d = vc_line;
        state_d  = StDone;
      end
      StWb: begin
        if (mem_ack) state_d = StFill;
      end
      StFill: begin
        if (mem_ack) begin
          result_d = mem_rdata;
          state_d  = StRefill;
        end
      end
      StRefill: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  line_word_mux u_result_mux (
    .line_i (result_q),
    .sel_i  (addr_q[2:0]),
    .word_o (result_word)
  );

  // Outputs decode from the registered state; only stall looks at inputs, and only in IDLE.
  always_comb begin
    vc_addr      = '0;
    vc_evict     = 1'b0;
    vc_in_line   = '0;
    l1_fill_we   = 1'b0;
    l1_fill_line = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    stall        = 1'b1;
    done         = 1'b0;
    dout         = '0;
    unique case (state_q)
      StIdle:  stall = req_valid && !l1_hit;
      StProbe: vc_addr = addr_q[ADDR_W-1:3];
      StSwap: begin
        l1_fill_we   = 1'b1;
        l1_fill_line = vc_line;
        vc_evict     = vic_valid_q;
        vc_in_line   = vic_line_q;
      end
      StWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = vic_addr_q;
        mem_wdata = vic_line_q;
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = addr_q[ADDR_W-1:3];
      end
      StRefill: begin
        l1_fill_we   = 1'b1;
        l1_fill_line = result_q;
        vc_evict     = vic_valid_q;
        vc_in_line   = vic_line_q;
      end
      StDone: begin
        stall = 1'b0;
        done  = 1'b1;
        dout  = result_word;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Randomized self-checking bench for victim_swap_ctrl against a per-cycle timeline model.
module tb_victim_swap_ctrl;

  typedef struct packed {
    logic         stall;
    logic         done;
    logic [31:0]  dout;
    logic         mem_req;
    logic         mem_we;
    logic [19:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         fill_we;
    logic [255:0] fill_line;
    logic         evict;
    logic [255:0] in_line;
    logic [19:0]  vc_addr;
  } obs_t;

  typedef struct {
    logic [22:0]  addr;
    logic         vvalid;
    logic         vdirty;
    logic [19:0]  vaddr;
    logic [255:0] vline;
    logic         vchit;
    logic [255:0] vcline;
    int           wb_lat;
    int           fill_lat;
    logic [255:0] rdata;
    logic         loud;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, l1_hit, l1_victim_valid, l1_victim_dirty;
  logic [22:0]  req_addr;
  logic [19:0]  l1_victim_addr, vc_addr, mem_addr;
  logic [255:0] l1_victim_line, vc_line, vc_in_line, l1_fill_line, mem_wdata, mem_rdata;
  logic         vc_hit, vc_evict, l1_fill_we, mem_req, mem_we, mem_ack, stall, done;
  logic [31:0]  dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  victim_swap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .l1_hit          (l1_hit),
    .l1_victim_valid (l1_victim_valid),
    .l1_victim_dirty (l1_victim_dirty),
    .l1_victim_addr  (l1_victim_addr),
    .l1_victim_line  (l1_victim_line),
    .vc_hit          (vc_hit),
    .vc_line         (vc_line),
    .vc_addr         (vc_addr),
    .vc_evict        (vc_evict),
    .vc_in_line      (vc_in_line),
    .l1_fill_we      (l1_fill_we),
    .l1_fill_line    (l1_fill_line),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .stall           (stall),
    .done            (done),
    .dout            (dout)
  );

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.stall = stall;       o.done = done;           o.dout = dout;
    o.mem_req = mem_req;   o.mem_we = mem_we;       o.mem_addr = mem_addr;
    o.mem_wdata = mem_wdata;
    o.fill_we = l1_fill_we; o.fill_line = l1_fill_line;
    o.evict = vc_evict;    o.in_line = vc_in_line;  o.vc_addr = vc_addr;
    return o;
  endfunction

  // Timeline: request(0), probe(1), optional writeback, fill, install, done.
  function automatic obs_t model(input txn_t t, input int cyc);
    obs_t e = '0;
    int wb_n, fill0, inst, done_c;
    logic [255:0] result;
    logic [2:0] sel;
    wb_n   = (!t.vchit && t.vvalid && t.vdirty) ? t.wb_lat : 0;
    fill0  = 2 + wb_n;
    inst   = t.vchit ? 2 : fill0 + t.fill_lat;
    done_c = inst + 1;
    result = t.vchit ? t.vcline : t.rdata;
    sel    = t.addr[2:0];
    if (cyc < done_c) e.stall = 1'b1;
    if (cyc == 1) e.vc_addr = t.addr[22:3];
    if (!t.vchit && cyc >= 2 && cyc < fill0) begin
      e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr = t.vaddr; e.mem_wdata = t.vline;
    end
    if (!t.vchit && cyc >= fill0 && cyc < inst) begin
      e.mem_req = 1'b1; e.mem_addr = t.addr[22:3];
    end
    if (cyc == inst) begin
      e.fill_we = 1'b1; e.fill_line = result; e.evict = t.vvalid; e.in_line = t.vline;
    end
    if (cyc == done_c) begin
      e.done = 1'b1; e.dout = result[32*sel +: 32];
    end
    return e;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr = 23'($urandom);      t.vvalid = 1'($urandom);  t.vdirty = 1'($urandom);
    t.vaddr = 20'($urandom);     t.vline = rand_line();    t.vchit = 1'($urandom);
    t.vcline = rand_line();      t.wb_lat = int'($urandom_range(1, 4));
    t.fill_lat = int'($urandom_range(1, 4));               t.rdata = rand_line();
    t.loud = 1'($urandom);
    return t;
  endfunction

  task automatic noise_side();
    req_addr = 23'($urandom);
    l1_victim_valid = 1'($urandom); l1_victim_dirty = 1'($urandom);
    l1_victim_addr = 20'($urandom); l1_victim_line = rand_line();
  endtask

  task automatic idle_gap(input int n, input logic force_ack, input string tag);
    obs_t o;
    for (int c = 0; c < n; c++) begin
      noise_side();
      req_valid = 1'($urandom); l1_hit = 1'b1;
      vc_hit = 1'($urandom); vc_line = rand_line();
      mem_ack = force_ack | 1'($urandom); mem_rdata = rand_line();
      #2;
      o = observe();
      checks++;
      if (o !== '0) begin
        failures++;
        $display("FAIL %s idle: got stall=%b done=%b mem_req=%b fill_we=%b evict=%b, want all 0",
                 tag, o.stall, o.done, o.mem_req, o.fill_we, o.evict);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_txn(input txn_t t, input string tag, output int stall_cnt,
                         output int req_cnt, output int we_cnt, output int done_cyc,
                         output logic [31:0] dout_seen);
    obs_t o, e;
    int wb_n, fill0, inst;
    wb_n  = (!t.vchit && t.vvalid && t.vdirty) ? t.wb_lat : 0;
    fill0 = 2 + wb_n;
    inst  = t.vchit ? 2 : fill0 + t.fill_lat;
    stall_cnt = 0; req_cnt = 0; we_cnt = 0; done_cyc = -1; dout_seen = '0;
    for (int c = 0; c <= inst + 1; c++) begin
      if (c == 0) begin
        req_valid = 1'b1; l1_hit = 1'b0; req_addr = t.addr;
        l1_victim_valid = t.vvalid; l1_victim_dirty = t.vdirty;
        l1_victim_addr = t.vaddr;   l1_victim_line = t.vline;
      end else begin
        noise_side();
        req_valid = t.loud | 1'($urandom);
        l1_hit = t.loud ? 1'b0 : 1'($urandom);
      end
      vc_hit  = (c == 1) ? t.vchit : 1'($urandom);
      vc_line = (c == 2 && t.vchit) ? t.vcline : rand_line();
      if (!t.vchit && c >= 2 && c < inst)
        mem_ack = (wb_n > 0 && c == fill0 - 1) || (c == inst - 1);
      else
        mem_ack = 1'($urandom);
      mem_rdata = (!t.vchit && c == inst - 1) ? t.rdata : rand_line();
      #2;
      o = observe();
      e = model(t, c);
      checks++;
      if (o !== e) begin
        failures++;
        $display({"FAIL %s cyc=%0d got st=%b dn=%b do=%h rq=%b we=%b ma=%h wd=%h fw=%b fl=%h ",
                  "ev=%b il=%h va=%h | want st=%b dn=%b do=%h rq=%b we=%b ma=%h wd=%h fw=%b ",
                  "fl=%h ev=%b il=%h va=%h"},
                 tag, c, o.stall, o.done, o.dout, o.mem_req, o.mem_we, o.mem_addr,
                 o.mem_wdata[31:0], o.fill_we, o.fill_line[31:0], o.evict, o.in_line[31:0],
                 o.vc_addr, e.stall, e.done, e.dout, e.mem_req, e.mem_we, e.mem_addr,
                 e.mem_wdata[31:0], e.fill_we, e.fill_line[31:0], e.evict, e.in_line[31:0],
                 e.vc_addr);
      end
      if (o.stall) stall_cnt++;
      if (o.mem_req) req_cnt++;
      if (o.mem_req && o.mem_we) we_cnt++;
      if (o.done) begin done_cyc = c; dout_seen = o.dout; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0; req_valid = 1'b1; l1_hit = 1'b0; mem_ack = 1'b0;
    noise_side(); vc_hit = 1'b0; vc_line = '0; mem_rdata = '0;
    @(posedge clk); #1;
    #2;
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got mem_req=%b done=%b, want 0 0", mem_req, done);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #2;
    o = observe();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_release: got stall=%b mem_req=%b done=%b, want all 0",
               o.stall, o.mem_req, o.done);
    end
    @(posedge clk); #1;
    idle_gap(4, 1'b0, "l1_hit_no_action");
  endtask

  task automatic test_victim_hit();
    txn_t t;
    int sc, rc, wc, dc;
    logic [31:0] dw;
    t = rand_txn();
    t.addr = 23'h000015; t.vchit = 1'b1; t.vvalid = 1'b1; t.loud = 1'b0;
    t.vcline[32*5 +: 32] = 32'hCAFEF00D;
    run_txn(t, "victim_hit", sc, rc, wc, dc, dw);
    checks++;
    if (dc != 3 || dw !== 32'hCAFEF00D || rc != 0 || sc != 3) begin
      failures++;
      $display("FAIL victim_hit_summary: got done_cyc=%0d dout=%h mem_req_cycles=%0d stall=%0d, want 3 cafef00d 0 3",
               dc, dw, rc, sc);
    end
  endtask

  task automatic test_clean_miss();
    txn_t t;
    int sc, rc, wc, dc;
    logic [31:0] dw;
    t = rand_txn();
    t.addr = {20'h2468A, 3'd0}; t.vchit = 1'b0; t.vvalid = 1'b1; t.vdirty = 1'b0;
    t.fill_lat = 4; t.rdata[31:0] = 32'h12345678; t.loud = 1'b0;
    run_txn(t, "clean_miss", sc, rc, wc, dc, dw);
    checks++;
    if (sc != 7 || dw !== 32'h12345678 || wc != 0 || rc != 4) begin
      failures++;
      $display("FAIL clean_miss_summary: got stall=%0d dout=%h wb_cycles=%0d req_cycles=%0d, want 7 12345678 0 4",
               sc, dw, wc, rc);
    end
  endtask

  task automatic test_dirty_miss();
    txn_t t;
    int sc, rc, wc, dc;
    logic [31:0] dw;
    t = rand_txn();
    t.vchit = 1'b0; t.vvalid = 1'b1; t.vdirty = 1'b1; t.vaddr = 20'hABCDE;
    t.wb_lat = 2; t.fill_lat = 3; t.loud = 1'b0;
    run_txn(t, "dirty_miss", sc, rc, wc, dc, dw);
    checks++;
    if (wc != 2 || rc != 5 || sc != 8) begin
      failures++;
      $display("FAIL dirty_miss_summary: got wb_cycles=%0d req_cycles=%0d stall=%0d, want 2 5 8",
               wc, rc, sc);
    end
    // Ack lands on the first request cycle of both phases.
    t = rand_txn();
    t.vchit = 1'b0; t.vvalid = 1'b1; t.vdirty = 1'b1; t.wb_lat = 1; t.fill_lat = 1;
    run_txn(t, "dirty_miss_fast_ack", sc, rc, wc, dc, dw);
  endtask

  task automatic test_reset_mid_fill();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        req_valid = 1'b1; l1_hit = 1'b0; req_addr = 23'h1ABCD5;
        l1_victim_valid = 1'b0; l1_victim_dirty = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      vc_hit = 1'b0; mem_ack = 1'b0;
      if (c == 3) rst = 1'b0;
      #2;
      if (c == 2) begin
        checks++;
        if (mem_req !== 1'b1) begin
          failures++;
          $display("FAIL mid_fill_req: got mem_req=%b, want 1", mem_req);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b0; mem_ack = 1'b1;
      #2;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL mid_fill_reset c=%0d: got mem_req=%b stall=%b done=%b, want 0 0 0",
                 c, mem_req, stall, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignored_inputs();
    txn_t t;
    int sc, rc, wc, dc;
    logic [31:0] dw;
    idle_gap(3, 1'b1, "spurious_ack_idle");
    t = rand_txn();
    t.vchit = 1'b0; t.vvalid = 1'b1; t.vdirty = 1'b0; t.fill_lat = 3; t.loud = 1'b1;
    run_txn(t, "req_during_fill", sc, rc, wc, dc, dw);
  endtask

  task automatic test_back_to_back();
    txn_t t;
    int sc, rc, wc, dc;
    logic [31:0] dw;
    for (int i = 0; i < 40; i++) begin
      t = rand_txn();
      run_txn(t, $sformatf("random%0d", i), sc, rc, wc, dc, dw);
      if ($urandom_range(0, 2) == 0) idle_gap(int'($urandom_range(1, 3)), 1'b0, "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_victim_hit();
    test_clean_miss();
    test_dirty_miss();
    idle_gap(1, 1'b0, "post_dirty");
    test_reset_mid_fill();
    test_ignored_inputs();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/victim_swap_ctrl.md
# victim_swap_ctrl

Miss sequencer sitting between the L1 data cache, the 4-entry victim cache and the memory interface. On an L1 miss it probes the victim cache. On a victim hit it swaps the two lines. On a victim miss it writes back a dirty L1 victim, fills the line from memory, and pushes the clean L1 victim into the victim cache. It stalls the processor throughout and returns the requested word on completion.

## Interface
Parameters:
- ADDR_W, 23, word address width (8 words per line, block address = ADDR_W-3 = 20 bits)
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  processor access this cycle
- req_addr  in  23  word address
- l1_hit  in  1  L1 tag hit for req_addr (combinational from L1)
- l1_victim_valid  in  1  L1 line at the target index is valid
- l1_victim_dirty  in  1  that line is dirty
- l1_victim_addr  in  20  block address of that line
- l1_victim_line  in  256  data of that line
- vc_hit  in  1  victim cache hit for the registered block address
- vc_line  in  256  victim cache line on hit
- vc_addr  out  20  block address presented to the victim cache
- vc_evict  out  1  one-cycle push of vc_in_line into the victim cache
- vc_in_line  out  256  line pushed into the victim cache
- l1_fill_we  out  1  one-cycle L1 line write
- l1_fill_line  out  256  line written into L1
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = line writeback, 0 = line read
- mem_addr  out  20  block address
- mem_wdata  out  256  writeback data
- mem_ack  in  1  memory accepted or completed the request
- mem_rdata  in  256  fill data, valid with mem_ack on reads
- stall  out  1  processor must hold
- done  out  1  one-cycle pulse; dout valid
- dout  out  32  requested word

## Operation
- States: IDLE, PROBE, SWAP, WB, FILL, REFILL, DONE.
- Reset (rst=0 at a clock edge): state ← IDLE. All registered outputs and latched data ← 0. Applies mid-operation: an outstanding mem_req is dropped; the memory side is reset in the same cycle.
- IDLE: on req_valid & ~l1_hit:
  - latch req_addr, l1_victim_valid, l1_victim_dirty, l1_victim_addr and l1_victim_line;
  - go to PROBE.
  - req_valid & l1_hit: no action.
- PROBE: vc_addr = latched req_addr[22:3]. Next state:
  - vc_hit → SWAP;
  - else if victim valid & dirty → WB;
  - else → FILL.
- SWAP (1 cycle):
  - l1_fill_we=1, l1_fill_line=vc_line;
  - vc_evict = latched victim valid, vc_in_line = latched victim line;
  - latch vc_line as the result line;
  - → DONE.
- WB: mem_req=1, mem_we=1, mem_addr = victim block address, mem_wdata = victim line. On mem_ack → FILL.
- FILL: mem_req=1, mem_we=0, mem_addr = req block address. On mem_ack: latch mem_rdata as the result line, → REFILL.
- REFILL (1 cycle):
  - l1_fill_we=1 with the result line;
  - vc_evict = latched victim valid, vc_in_line = victim line (now clean);
  - → DONE.
- Victim cache holds clean lines only. Dirty data always reaches memory before the push.
- DONE (1 cycle): done=1, dout = result line word addr[2:0] (word k = bits 32k+31:32k), → IDLE.
- req_valid is ignored outside IDLE. mem_ack is ignored when mem_req=0.
- Victim cache LRU update is triggered by vc_evict and by the SWAP cycle. The victim cache owns its replacement state.

## Timing
- stall = (state≠IDLE & state≠DONE) | (state==IDLE & req_valid & ~l1_hit). It is combinational in IDLE only and registered-state decoded otherwise.
- Victim hit: request in cycle 0 → PROBE 1 → SWAP 2 → DONE 3. Stall is high for cycles 0-2.
- Clean miss, ack after A cycles in FILL: total stall = 3 + A cycles.
- Dirty miss: add the WB duration.
- mem_req rises on the cycle after state entry. It stays high through the ack cycle. The state advances on the ack edge. Between WB and FILL, mem_req stays high with mem_we changing 1→0.
- ack in the first cycle of mem_req is legal.
- Back-to-back: a new request in the cycle after DONE (IDLE) is accepted.
- All outputs read 0 after reset and in IDLE, except stall as defined.

## Structure
- Shared package holds:
  - the state enum;
  - ADDR_W, LINE_W, BLK_W=ADDR_W-3, WORDS=8;
  - a line-to-word select function.
- One natural sub-module, line_word_mux: 256-bit line and 3-bit select to a 32-bit word. It is reused by the victim cache and L1 read paths.

## Test plan
- Reset: hold rst=0 for 2 cycles with req_valid=1 → stall=0 after release, mem_req=0, done=0, state IDLE.
- Victim hit: req_addr=23'h000015, vc_hit=1, vc_line word5=32'hCAFEF00D, victim valid → l1_fill_we and vc_evict pulse in cycle 2, done in cycle 3 with dout=32'hCAFEF00D, mem_req never asserted.
- Clean miss: vc_hit=0, victim clean, mem_ack 4 cycles after mem_req, mem_rdata word0=32'h12345678, addr[2:0]=0 → mem_we=0, mem_addr=req[22:3], dout=32'h12345678, stall for 7 cycles.
- Dirty miss: victim dirty, victim_addr=20'hABCDE → WB with mem_we=1, mem_addr=20'hABCDE, then FILL, then vc_in_line equals the old victim line.
- Reset mid-FILL: drive rst=0 while mem_req=1 → next cycle mem_req=0, stall=0, no done pulse.
- Spurious mem_ack in IDLE and req_valid during FILL → both ignored; the sequence completes with the original address.
